pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/bubble sequencer for the 5-stage pipeline (regF/regD/regE/regM/regW).
//  Resolves four hazard sources: data-memory wait, multi-cycle mul/div wait,
//  load-use dependency and branch/jump redirect.
//  Drives the *_stall / *_bubble inputs of every pipeline register.
//  Holds a small wait-state FSM, a memory watchdog and a stall-cycle performance counter.
// PARAMETERS
//  WDOG_W   8   width of the data-memory wait watchdog counter
//  WDOG_MAX 200 MEM_WAIT cycle count that raises err_mem_timeout
//  PERF_W   64  width of the stall-cycle performance counter
// PORTS
//  clk              in  1  clock, rising edge
//  rst              in  1  asynchronous, active-high reset
//  regD_i_rs1       in  5  rs1 of the instruction in decode
//  regD_i_rs2       in  5  rs2 of the instruction in decode
//  regD_i_use_rs1   in  1  decode instruction reads rs1
//  regD_i_use_rs2   in  1  decode instruction reads rs2
//  regE_i_rd        in  5  rd of the instruction in execute
//  regE_i_is_load   in  1  execute instruction is a load
//  regE_i_md_start  in  1  execute instruction is mul/div (first cycle in E)
//  md_i_done        in  1  mul/div result valid this cycle
//  exe_i_redirect   in  1  taken branch/jump resolved in E
//  regM_i_mem_req   in  1  memory stage issues load/store
//  dmem_i_ready     in  1  data memory accepts/returns this cycle
//  regF_stall       out 1  hold fetch PC/instr
//  regD_stall/regD_bubble, regE_stall/regE_bubble   out 1 each
//  regM_stall/regM_bubble, regW_stall/regW_bubble   out 1 each
//  err_mem_timeout  out 1  sticky: MEM_WAIT exceeded WDOG_MAX
//  perf_stall_cnt   out PERF_W  cycles in which regF_stall=1
// BEHAVIOUR
//  - FSM state register {IDLE, MEM_WAIT, MD_WAIT}; outputs combinational from state + inputs.
//  - rst asserted: state=IDLE, watchdog=0, err_mem_timeout=0, perf_stall_cnt=0;
//    all *_stall=0, all *_bubble=1 (full flush) while rst is high.
//  - Priority per cycle (highest first), only one rule applies:
//    1 mem wait  (state==MEM_WAIT, or IDLE & mem_req & !dmem_ready):
//      stall F,D,E,M; bubble W.
//    2 md wait   (state==MD_WAIT, or IDLE & md_start & !md_done):
//      stall F,D,E; bubble M.
//    3 redirect  (exe_redirect): bubble D and E; no stalls; load-use ignored.
//    4 load-use  (is_load & rd!=0 & ((use_rs1 & rs1==rd) | (use_rs2 & rs2==rd))):
//      stall F,D; bubble E.
//    5 none: all stall=0, bubble=0.
//  - Stall and bubble of the same stage are never both 1.
//  - Transitions:
//    IDLE -> MEM_WAIT if mem_req & !dmem_ready.
//    IDLE -> MD_WAIT  if not going to MEM_WAIT and md_start & !md_done.
//    MEM_WAIT -> IDLE when dmem_ready; that cycle is still stalled; release next cycle.
//    MD_WAIT -> IDLE when md_done (same rule as MEM_WAIT).
//    mem_req is ignored in MD_WAIT (M already holds a bubble).
//  - Redirect asserted during MEM_WAIT/MD_WAIT is ignored; E is stalled, so the source
//    re-asserts it after release.
//  - Watchdog: cleared on entering MEM_WAIT.
//    Increments each MEM_WAIT cycle, saturating at 2^WDOG_W-1.
//    count==WDOG_MAX sets err_mem_timeout (sticky until rst).
//    The FSM keeps waiting; there is no auto-abort.
//  - perf_stall_cnt += 1 every cycle regF_stall=1; wraps modulo 2^PERF_W.
// STRUCTURE
//  - Shared package pipe_ctrl_pkg: FSM state enum (2-bit), zero-register constant,
//    and the per-stage {stall,bubble} control typedef.
//  - One sub-module: pipe_hazard_detect, the pure combinational load-use comparator.
//  - FSM, watchdog and perf counter stay in the top module.
// TESTING
//  - Load-use: E is_load rd=5, D rs1=5 use_rs1 -> one cycle regF/regD_stall=1,
//    regE_bubble=1. Repeat with rd=0 -> no stall.
//  - Redirect + load-use in the same cycle -> regD_bubble=regE_bubble=1,
//    regF_stall=0, regD_stall=0.
//  - Mem wait: mem_req=1, dmem_ready low for 3 cycles -> F..M stalled and
//    regW_bubble=1 for 4 cycles total; perf_stall_cnt +4.
//  - Mul/div: md_start with md_done after 5 cycles -> F..E stalled, regM_bubble=1
//    throughout; state returns to IDLE.
//  - Watchdog: WDOG_MAX=10, dmem_ready held low 12 cycles -> err_mem_timeout rises
//    on the 10th wait cycle and stays 1 after ready.
//  - Async rst mid-MEM_WAIT -> immediately all bubbles=1, stalls=0, counters 0,
//    IDLE after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// the hard-wired zero register index and the per-stage stall/bubble pair.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMemWait = 2'd1,
    StMdWait  = 2'd2
  } state_e;

  localparam logic [4:0] ZeroReg = 5'd0;

  typedef struct packed {
    logic stall;
    logic bubble;
  } stage_ctrl_t;

  localparam stage_ctrl_t StageRun   = '{stall: 1'b0, bubble: 1'b0};
  localparam stage_ctrl_t StageHold  = '{stall: 1'b1, bubble: 1'b0};
  localparam stage_ctrl_t StageFlush = '{stall: 1'b0, bubble: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, per-stage stall/bubble and
// diagnostics out. The pipeline side is master, the controller is slave.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned PERF_W = 64
) ();

  logic [4:0]        regD_i_rs1;
  logic [4:0]        regD_i_rs2;
  logic              regD_i_use_rs1;
  logic              regD_i_use_rs2;
  logic [4:0]        regE_i_rd;
  logic              regE_i_is_load;
  logic              regE_i_md_start;
  logic              md_i_done;
  logic              exe_i_redirect;
  logic              regM_i_mem_req;
  logic              dmem_i_ready;

  logic              regF_stall;
  logic              regD_stall;
  logic              regD_bubble;
  logic              regE_stall;
  logic              regE_bubble;
  logic              regM_stall;
  logic              regM_bubble;
  logic              regW_stall;
  logic              regW_bubble;
  logic              err_mem_timeout;
  logic [PERF_W-1:0] perf_stall_cnt;

  modport master (
    output regD_i_rs1, regD_i_rs2, regD_i_use_rs1, regD_i_use_rs2,
    output regE_i_rd, regE_i_is_load, regE_i_md_start, md_i_done,
    output exe_i_redirect, regM_i_mem_req, dmem_i_ready,
    input  regF_stall, regD_stall, regD_bubble, regE_stall, regE_bubble,
    input  regM_stall, regM_bubble, regW_stall, regW_bubble,
    input  err_mem_timeout, perf_stall_cnt
  );

  modport slave (
    input  regD_i_rs1, regD_i_rs2, regD_i_use_rs1, regD_i_use_rs2,
    input  regE_i_rd, regE_i_is_load, regE_i_md_start, md_i_done,
    input  exe_i_redirect, regM_i_mem_req, dmem_i_ready,
    output regF_stall, regD_stall, regD_bubble, regE_stall, regE_bubble,
    output regM_stall, regM_bubble, regW_stall, regW_bubble,
    output err_mem_timeout, perf_stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use comparator: flags a decode operand that depends on
// a load still sitting in execute.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic [4:0] rd,
  input  logic       is_load,
  output logic       load_use
);

  logic match_rs1;
  logic match_rs2;

  always_comb begin
    match_rs1 = use_rs1 && (rs1 == rd);
    match_rs2 = use_rs2 && (rs2 == rd);
    // x0 never carries a real dependency
    load_use  = is_load && (rd != ZeroReg) && (match_rs1 || match_rs2);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble sequencer for the 5-stage pipeline, with wait-state FSM,
// data-memory watchdog and stall-cycle performance counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WDOG_W   = 8,
  parameter int unsigned WDOG_MAX = 200,
  parameter int unsigned PERF_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic        load_use;
  logic        idle;
  logic        mem_wait;
  logic        md_wait;
  logic        f_stall;
  stage_ctrl_t d_ctrl, e_ctrl, m_ctrl, w_ctrl;

  pipe_hazard_detect u_detect (
    .rs1      (bus.regD_i_rs1),
    .rs2      (bus.regD_i_rs2),
    .use_rs1  (bus.regD_i_use_rs1),
    .use_rs2  (bus.regD_i_use_rs2),
    .rd       (bus.regE_i_rd),
    .is_load  (bus.regE_i_is_load),
    .load_use (load_use)
  );

  // The first wait cycle is decided from IDLE inputs, so no cycle slips.
  always_comb begin
    idle     = (state_q == StIdle);
    mem_wait = (state_q == StMemWait) ||
               (idle && bus.regM_i_mem_req && !bus.dmem_i_ready);
    md_wait  = !mem_wait && ((state_q == StMdWait) ||
               (idle && bus.regE_i_md_start && !bus.md_i_done));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.regM_i_mem_req && !bus.dmem_i_ready) begin
          state_d = StMemWait;
        end else if (bus.regE_i_md_start && !bus.md_i_done) begin
          state_d = StMdWait;
        end
      end
      StMemWait: if (bus.dmem_i_ready) state_d = StIdle;
      StMdWait:  if (bus.md_i_done)    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    f_stall = 1'b0;
    d_ctrl  = StageRun;
    e_ctrl  = StageRun;
    m_ctrl  = StageRun;
    w_ctrl  = StageRun;
    if (rst) begin
      d_ctrl = StageFlush;
      e_ctrl = StageFlush;
      m_ctrl = StageFlush;
      w_ctrl = StageFlush;
    end else if (mem_wait) begin
      f_stall = 1'b1;
      d_ctrl  = StageHold;
      e_ctrl  = StageHold;
      m_ctrl  = StageHold;
      w_ctrl  = StageFlush;
    end else if (md_wait) begin
      f_stall = 1'b1;
      d_ctrl  = StageHold;
      e_ctrl  = StageHold;
      m_ctrl  = StageFlush;
    end else if (bus.exe_i_redirect) begin
      // Wrong-path instructions in D and E are squashed; any load-use is moot
      d_ctrl = StageFlush;
      e_ctrl = StageFlush;
    end else if (load_use) begin
      f_stall = 1'b1;
      d_ctrl  = StageHold;
      e_ctrl  = StageFlush;
    end
  end

  // err rises on the edge where the post-increment count reaches WDOG_MAX.
  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q;
    if (idle && mem_wait) begin
      wdog_d = '0;
    end else if (state_q == StMemWait) begin
      if (wdog_q != {WDOG_W{1'b1}}) wdog_d = wdog_q + 1'b1;
      if (wdog_d == WDOG_W'(WDOG_MAX)) err_d = 1'b1;
    end
    perf_d = f_stall ? perf_q + PERF_W'(1) : perf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      perf_q  <= perf_d;
    end
  end

  assign bus.regF_stall      = f_stall;
  assign bus.regD_stall      = d_ctrl.stall;
  assign bus.regD_bubble     = d_ctrl.bubble;
  assign bus.regE_stall      = e_ctrl.stall;
  assign bus.regE_bubble     = e_ctrl.bubble;
  assign bus.regM_stall      = m_ctrl.stall;
  assign bus.regM_bubble     = m_ctrl.bubble;
  assign bus.regW_stall      = w_ctrl.stall;
  assign bus.regW_bubble     = w_ctrl.bubble;
  assign bus.err_mem_timeout = err_q;
  assign bus.perf_stall_cnt  = perf_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control vectors are queued as
// stimulus is applied and checked when the outputs settle.
module tb_pipe_hazard_ctrl;

  localparam int unsigned PerfW = 64;

  // {F.stall, D.stall, D.bubble, E.stall, E.bubble, M.stall, M.bubble, W.stall, W.bubble}
  localparam logic [8:0] CNone = 9'b000000000;
  localparam logic [8:0] CMem  = 9'b110101001;
  localparam logic [8:0] CMd   = 9'b110100100;
  localparam logic [8:0] CRdr  = 9'b001010000;
  localparam logic [8:0] CLu   = 9'b110010000;
  localparam logic [8:0] CRst  = 9'b001010101;

  typedef struct {
    string            tag;
    logic [8:0]       ctrl;
    logic [PerfW-1:0] perf;
    logic             err;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   n_tests;
  int   n_fail;
  logic [PerfW-1:0] perf_exp;

  pipe_hazard_ctrl_if #(.PERF_W(PerfW)) bus ();

  pipe_hazard_ctrl #(
    .WDOG_W   (8),
    .WDOG_MAX (10),
    .PERF_W   (PerfW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    bus.regD_i_rs1      = 5'd0;
    bus.regD_i_rs2      = 5'd0;
    bus.regD_i_use_rs1  = 1'b0;
    bus.regD_i_use_rs2  = 1'b0;
    bus.regE_i_rd       = 5'd0;
    bus.regE_i_is_load  = 1'b0;
    bus.regE_i_md_start = 1'b0;
    bus.md_i_done       = 1'b0;
    bus.exe_i_redirect  = 1'b0;
    bus.regM_i_mem_req  = 1'b0;
    bus.dmem_i_ready    = 1'b0;
  endtask

  task automatic compare_head();
    exp_t       e;
    logic [8:0] obs;
    e   = sb.pop_front();
    obs = {bus.regF_stall, bus.regD_stall, bus.regD_bubble, bus.regE_stall, bus.regE_bubble,
           bus.regM_stall, bus.regM_bubble, bus.regW_stall, bus.regW_bubble};
    n_tests++;
    assert (obs === e.ctrl) else begin
      n_fail++;
      $error("FAIL %s ctrl: observed %b expected %b", e.tag, obs, e.ctrl);
    end
    n_tests++;
    assert (bus.perf_stall_cnt === e.perf) else begin
      n_fail++;
      $error("FAIL %s perf: observed %0d expected %0d", e.tag, bus.perf_stall_cnt, e.perf);
    end
    n_tests++;
    assert (bus.err_mem_timeout === e.err) else begin
      n_fail++;
      $error("FAIL %s err: observed %b expected %b", e.tag, bus.err_mem_timeout, e.err);
    end
  endtask

  // Inputs are already driven; check at the falling edge, then clock once.
  task automatic step(input string tag, input logic [8:0] ctrl, input logic err);
    sb.push_back('{tag: tag, ctrl: ctrl, perf: perf_exp, err: err});
    @(negedge clk);
    compare_head();
    @(posedge clk);
    if (ctrl[8]) perf_exp = perf_exp + 1;
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    perf_exp = '0;
    clr();
    rst = 1'b1;
    step("reset", CRst, 1'b0);
    rst = 1'b0;
    step("idle", CNone, 1'b0);

    bus.regE_i_is_load = 1'b1; bus.regE_i_rd = 5'd5;
    bus.regD_i_rs1 = 5'd5; bus.regD_i_use_rs1 = 1'b1;
    step("lu_rs1", CLu, 1'b0);
    clr();
    step("lu_release", CNone, 1'b0);
    bus.regE_i_is_load = 1'b1; bus.regE_i_rd = 5'd0;
    bus.regD_i_rs1 = 5'd0; bus.regD_i_use_rs1 = 1'b1;
    step("lu_rd0", CNone, 1'b0);
    clr();
    bus.regE_i_is_load = 1'b1; bus.regE_i_rd = 5'd7;
    bus.regD_i_rs1 = 5'd3; bus.regD_i_use_rs1 = 1'b1;
    bus.regD_i_rs2 = 5'd7; bus.regD_i_use_rs2 = 1'b1;
    step("lu_rs2", CLu, 1'b0);
    clr();
    bus.regE_i_is_load = 1'b1; bus.regE_i_rd = 5'd7;
    bus.regD_i_rs1 = 5'd7; bus.regD_i_rs2 = 5'd2; bus.regD_i_use_rs2 = 1'b1;
    step("lu_unused_rs1", CNone, 1'b0);
    clr();
    bus.regE_i_rd = 5'd7; bus.regD_i_rs1 = 5'd7; bus.regD_i_use_rs1 = 1'b1;
    step("no_load", CNone, 1'b0);
    bus.regE_i_is_load = 1'b1; bus.exe_i_redirect = 1'b1;
    step("redirect_lu", CRdr, 1'b0);
    clr();

    bus.regM_i_mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.dmem_i_ready = (i == 3);
      step("mem_wait", CMem, 1'b0);
    end
    clr();
    step("mem_release", CNone, 1'b0);
    bus.regM_i_mem_req = 1'b1; bus.dmem_i_ready = 1'b1;
    step("mem_hit", CNone, 1'b0);
    clr();

    bus.regE_i_md_start = 1'b1;
    step("md_enter", CMd, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      clr();
      bus.md_i_done      = (i == 5);
      bus.regM_i_mem_req = (i == 2);
      bus.exe_i_redirect = (i == 3);
      step("md_wait", CMd, 1'b0);
    end
    clr();
    step("md_release", CNone, 1'b0);
    bus.exe_i_redirect = 1'b1;
    step("redirect", CRdr, 1'b0);
    clr();
    bus.regE_i_md_start = 1'b1; bus.md_i_done = 1'b1;
    step("md_fast", CNone, 1'b0);
    clr();

    bus.regM_i_mem_req = 1'b1; bus.regE_i_md_start = 1'b1;
    step("mem_over_md", CMem, 1'b0);
    bus.regE_i_md_start = 1'b0; bus.dmem_i_ready = 1'b1;
    step("mem_over_md_rdy", CMem, 1'b0);
    clr();
    step("mem_over_md_rel", CNone, 1'b0);

    // 12 cycles with ready low, then one ready cycle, then released
    for (int j = 1; j <= 14; j++) begin
      clr();
      bus.regM_i_mem_req = (j <= 13);
      bus.dmem_i_ready   = (j == 13);
      step("wdog", (j <= 13) ? CMem : CNone, (j >= 12));
    end

    bus.regM_i_mem_req = 1'b1;
    step("rst_pre", CMem, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    perf_exp = '0;
    sb.push_back('{tag: "rst_async", ctrl: CRst, perf: perf_exp, err: 1'b0});
    compare_head();
    @(posedge clk);
    #3;
    rst = 1'b0;
    clr();
    step("post_rst_idle", CNone, 1'b0);
    bus.regM_i_mem_req = 1'b1; bus.dmem_i_ready = 1'b1;
    step("post_rst_hit", CNone, 1'b0);
    clr();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
